mapper_vector_player: RTL
=========================

Name: mapper_vector_player

Overview:
- Parametrised, synthesizable successor to the bench host-interface poker used around the mapper cores (MMC1 and later).
- Plays a preloaded table of stimulus vectors onto a mapper's CPU/PPU pins, one vector per CLK.
- Samples the mapper outputs one cycle later and compares them against per-vector expected values under a mask.
- Supports looping, early stop, error counting and first-failure capture, so the same mapper regression runs in sim and on FPGA.

Parameters:
- DRIVE_W, 9: width of the stimulus field (host pins driven into the mapper).
- SENSE_W, 16: width of the sensed field (mapper outputs compared).
- DEPTH_LOG2, 15: vector table depth is 2^DEPTH_LOG2 words.
- IDLE_DRIVE, 9'h100: value on `drive` when not playing (nROMSEL high, all else 0).
- HOLD_W, 4: hold-count field width; used only with VECTOR_HOLD_EN.

Ports:
- CLK, in, 1: single clock; all logic on the rising edge.
- RES, in, 1: synchronous reset, active-high.
- load_we, in, 1: table write strobe; ignored while busy.
- load_addr, in, DEPTH_LOG2: table write address.
- load_data, in, MEM_W: word laid out as {expect, mask, drive}, plus {hold} in the MSBs if enabled. MEM_W = DRIVE_W + 2*SENSE_W (+HOLD_W).
- start, in, 1: one-cycle pulse that begins playback at address 0.
- stop, in, 1: one-cycle pulse that ends playback early.
- loop_en, in, 1: wrap to address 0 after last_addr instead of finishing; sampled every cycle.
- last_addr, in, DEPTH_LOG2: index of the final vector; sampled at start.
- sense, in, SENSE_W: mapper outputs.
- drive, out, DRIVE_W: stimulus to the mapper.
- busy, out, 1: high from the cycle after start until DONE.
- done, out, 1: one-cycle pulse on completion or stop.
- err_cnt, out, 16: number of masked mismatches; saturates at 16'hFFFF.
- first_err_valid, out, 1: a mismatch has been captured.
- first_err_addr, out, DEPTH_LOG2: table index of the first mismatch.

Behaviour:
- Reset:
  - drive = IDLE_DRIVE; busy = 0; done = 0; err_cnt = 0; first_err_valid = 0; first_err_addr = 0; FSM = IDLE.
  - Table contents are not cleared.
  - RES mid-run returns all of the above to reset values on the next edge, with no done pulse.
- Table:
  - Single-port synchronous RAM with a 1-cycle read latency.
  - The write port is used only in IDLE/DONE.
- FSM states: IDLE, PRIME, RUN, DRAIN, DONE.
- IDLE:
  - start=1 → PRIME. On this edge: clear err_cnt and first_err_*, latch last_addr, issue read of address 0.
  - stop is ignored; if start and stop arrive together, start wins.
- PRIME (1 cycle): data for address 0 returns; drive ← vector 0 → RUN.
- RUN: the read address advances each cycle; drive ← the next vector each cycle, with no bubbles.
- Compare timing:
  - Vector k drives during cycle t.
  - `sense` is sampled at the edge ending cycle t+1 and compared against expect_k & mask_k. Expect and mask are pipelined alongside drive.
  - On mismatch, err_cnt increments (saturating at 16'hFFFF).
  - On the first mismatch, first_err_valid ← 1 and first_err_addr ← k.
- End of table:
  - After vector last_addr is driven: if loop_en=0 → DRAIN.
  - If loop_en=1 → vector 0 follows directly, with no bubble.
  - last_addr = 0 gives a single-vector run.
- DRAIN (1 cycle):
  - drive ← IDLE_DRIVE.
  - The final compare executes.
  - → DONE.
- stop in RUN:
  - Finish the compare of the vector currently driven, then → DRAIN on the next edge.
  - Vectors not yet driven are not applied.
- DONE (1 cycle): done=1, busy=0 → IDLE. Results hold until the next start or RES.
- start while busy is ignored.

Optional Feature:
- Macro: VECTOR_HOLD_EN.
- When defined:
  - Each word carries a HOLD_W hold field h.
  - The vector is driven for h+1 consecutive cycles.
  - Compare happens only on the last of those cycles (the next vector's read is issued so that there is no bubble).
  - stop during a hold ends after the current cycle's compare, which then counts.
- When undefined:
  - The field is absent, MEM_W omits HOLD_W, and each vector lasts exactly one cycle.

Test Plan:
- Load 4 vectors with mask=0; start with last_addr=3, loop_en=0.
  - drive shows vectors 0..3 on cycles 2..5 after start.
  - done pulses 2 cycles after vector 3; err_cnt=0.
- Vector 2 has expect=16'h0001, mask=16'h0001, sense tied to 0.
  - err_cnt=1, first_err_valid=1, first_err_addr=2.
- loop_en=1, last_addr=1, run 10 cycles, then pulse stop.
  - drive sequence 0,1,0,1,…
  - Exactly one more vector is compared, then drive=IDLE_DRIVE and done=1.
- Assert RES during RUN.
  - Next cycle: drive=9'h100, busy=0, err_cnt=0, no done pulse.
- Pulse start and stop together in IDLE; then pulse start while busy.
  - Run proceeds normally; the second start has no effect.
- Load a mismatching vector 0, last_addr=0, loop_en=1; run 70000 cycles.
  - err_cnt saturates at 16'hFFFF.
  - With VECTOR_HOLD_EN: h=3 holds drive for 4 cycles with one compare.

Source files
------------

// File: rtl/mapper_vector_player_if.sv
// mapper_vector_player_if: table load port plus the mapper pin bundle.
// MEM_W grows by HOLD_W when VECTOR_HOLD_EN is defined.
interface mapper_vector_player_if #(
    parameter int DRIVE_W    = 9,
    parameter int SENSE_W    = 16,
    parameter int DEPTH_LOG2 = 15,
    parameter int HOLD_W     = 4
);
`ifdef VECTOR_HOLD_EN
    localparam int HOLD_EN = 1;
`else
    localparam int HOLD_EN = 0;
`endif
    localparam int MEM_W =
        DRIVE_W + 2 * SENSE_W + HOLD_EN * HOLD_W;

    logic                  load_we;
    logic [DEPTH_LOG2-1:0] load_addr;
    logic [MEM_W-1:0]      load_data;
    logic [DRIVE_W-1:0]    drive;
    logic [SENSE_W-1:0]    sense;

    modport master (
        output load_we,
        output load_addr,
        output load_data,
        output sense,
        input  drive
    );

    modport slave (
        input  load_we,
        input  load_addr,
        input  load_data,
        input  sense,
        output drive
    );
endinterface

// File: rtl/mapper_vector_player.sv
// mapper_vector_player: plays stored vectors onto mapper pins, checks sense.
// Define VECTOR_HOLD_EN to give each vector a hold count (h+1 cycles).
module mapper_vector_player #(
    parameter int                 DRIVE_W    = 9,
    parameter int                 SENSE_W    = 16,
    parameter int                 DEPTH_LOG2 = 15,
    parameter logic [DRIVE_W-1:0] IDLE_DRIVE = 9'h100,
    parameter int                 HOLD_W     = 4
) (
    input  logic                  CLK,
    input  logic                  RES,
    mapper_vector_player_if.slave bus,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop_en,
    input  logic [DEPTH_LOG2-1:0] last_addr,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           err_cnt,
    output logic                  first_err_valid,
    output logic [DEPTH_LOG2-1:0] first_err_addr
);
`ifdef VECTOR_HOLD_EN
    localparam int HOLD_EN = 1;
`else
    localparam int HOLD_EN = 0;
`endif
    localparam int MEM_W =
        DRIVE_W + 2 * SENSE_W + HOLD_EN * HOLD_W;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [MEM_W-1:0]      mem [0:DEPTH-1];
    logic [MEM_W-1:0]      rdata;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic [DEPTH_LOG2-1:0] nxt_addr;
    logic [DEPTH_LOG2-1:0] last_q;
    logic [DEPTH_LOG2-1:0] cur_idx;
    logic [DEPTH_LOG2-1:0] cmp_idx;
    logic [DRIVE_W-1:0]    drive_q;
    logic [SENSE_W-1:0]    cur_exp;
    logic [SENSE_W-1:0]    cur_mask;
    logic [SENSE_W-1:0]    cmp_exp;
    logic [SENSE_W-1:0]    cmp_mask;
    logic                  cmp_v;
    logic                  mism;
    logic                  rd_en;
    logic                  we_ok;
    logic                  load_cur;
    logic                  push;
    logic                  clr;
    logic                  last_cyc;

    logic [DRIVE_W-1:0] r_drive;
    logic [SENSE_W-1:0] r_mask;
    logic [SENSE_W-1:0] r_exp;

    assign r_drive = rdata[DRIVE_W-1:0];
    assign r_mask  = rdata[DRIVE_W +: SENSE_W];
    assign r_exp   = rdata[DRIVE_W+SENSE_W +: SENSE_W];

`ifdef VECTOR_HOLD_EN
    logic [HOLD_W-1:0] hcnt;
    logic [HOLD_W-1:0] r_hold;

    assign r_hold   = rdata[MEM_W-1 -: HOLD_W];
    assign last_cyc = (hcnt == '0);

    always_ff @(posedge CLK) begin
        if (RES)
            hcnt <= '0;
        else if (load_cur)
            hcnt <= r_hold;
        else if (hcnt != '0)
            hcnt <= hcnt - 1'b1;
    end
`else
    assign last_cyc = 1'b1;
`endif

    // Prefetch wraps to 0 after last_addr so a loop has no bubble.
    assign nxt_addr =
        (rd_idx == last_q) ? '0 : rd_idx + 1'b1;

    assign we_ok = bus.load_we &&
        ((state == S_IDLE && !start) ||
         state == S_DONE);

    assign mism =
        |((bus.sense ^ cmp_exp) & cmp_mask);

    always_ff @(posedge CLK) begin
        if (we_ok)
            mem[bus.load_addr] <= bus.load_data;
        else if (rd_en)
            rdata <= mem[rd_addr];
    end

    always_ff @(posedge CLK) begin
        if (RES)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n  = state;
        rd_en    = 1'b0;
        rd_addr  = nxt_addr;
        load_cur = 1'b0;
        push     = 1'b0;
        clr      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_PRIME;
                    rd_en   = 1'b1;
                    rd_addr = '0;
                    clr     = 1'b1;
                end
            end
            S_PRIME: begin
                state_n  = S_RUN;
                rd_en    = 1'b1;
                load_cur = 1'b1;
            end
            S_RUN: begin
                if (stop || last_cyc) begin
                    push = 1'b1;
                    if (stop ||
                        (cur_idx == last_q && !loop_en)) begin
                        state_n = S_DRAIN;
                    end else begin
                        rd_en    = 1'b1;
                        load_cur = 1'b1;
                    end
                end
            end
            S_DRAIN: state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            rd_idx          <= '0;
            last_q          <= '0;
            cur_idx         <= '0;
            drive_q         <= IDLE_DRIVE;
            cur_exp         <= '0;
            cur_mask        <= '0;
            cmp_v           <= 1'b0;
            cmp_exp         <= '0;
            cmp_mask        <= '0;
            cmp_idx         <= '0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
        end else begin
            if (rd_en)
                rd_idx <= rd_addr;
            if (load_cur) begin
                drive_q  <= r_drive;
                cur_exp  <= r_exp;
                cur_mask <= r_mask;
                cur_idx  <= rd_idx;
            end else if (state_n != S_RUN) begin
                drive_q <= IDLE_DRIVE;
            end
            // Sense lags drive by one cycle, so compare one stage later.
            cmp_v <= push;
            if (push) begin
                cmp_exp  <= cur_exp;
                cmp_mask <= cur_mask;
                cmp_idx  <= cur_idx;
            end
            if (cmp_v && mism) begin
                if (err_cnt != 16'hFFFF)
                    err_cnt <= err_cnt + 16'd1;
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_addr  <= cmp_idx;
                end
            end
            if (clr) begin
                last_q          <= last_addr;
                err_cnt         <= '0;
                first_err_valid <= 1'b0;
                first_err_addr  <= '0;
            end
        end
    end

    assign bus.drive = drive_q;
    assign busy = (state == S_PRIME) ||
                  (state == S_RUN)   ||
                  (state == S_DRAIN);
    assign done = (state == S_DONE);
endmodule
